ps2_keyboard_init_seq: RTL
==========================

Name: ps2_keyboard_init_seq

Overview:
Parametrised successor to the single-command keyboard reset controller. After power-up it runs a full PS/2 keyboard init sequence: reset, wait for BAT, set typematic, set LEDs, enable scanning. It adds ACK timeout, bounded retry, BAT checking, re-init and a pass/fail status. It sits between the top level and the PS/2 host transmitter/receiver and drives the transmitter's command handshake.

Parameters:
WAIT_CYCLES, 500, clk cycles spent in S_IDLE before the first command (32-bit compare).
ACK_TIMEOUT, 100000, max clk cycles in S_WAIT_ACK before a timeout failure.
BAT_TIMEOUT, 50000000, max clk cycles in S_WAIT_BAT before a timeout failure.
MAX_RETRY, 3, retries allowed per byte before S_FAIL (1..15).
TYPEMATIC_ARG, 8'h20, argument byte sent after 0xF3.
LED_INIT, 3'b000, initial LED argument {caps,num,scroll} sent after 0xED.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
i_reinit  in  1  one-cycle pulse: restart the whole sequence
o_command_valid  out  1  one-cycle strobe to transmitter
o_command_data  out  8  byte to send; valid with o_command_valid, 8'h00 otherwise
i_command_ack  in  1  keyboard answered 0xFA
i_command_err  in  1  transmit error or 0xFE/resend
i_rx_valid  in  1  received-byte strobe
i_rx_data  in  8  received byte
i_led_req  in  1  runtime LED update request (optional feature)
i_led_val  in  3  runtime LED value
o_init_done  out  1  high while in S_DONE
o_init_fail  out  1  high while in S_FAIL
o_retry_cnt  out  4  retries used on the current byte
tp  out  8  {retry_cnt[1:0], step[2:0], state[2:0]}

Behaviour:
- Reset (rst_n low, async): state S_IDLE, step 0, all counters 0, all outputs 0.
- Step table (3-bit step): 0: 0xFF; 1: 0xF3; 2: TYPEMATIC_ARG; 3: 0xED; 4: {5'b0,LED}; 5: 0xF4. The LED register loads LED_INIT at reset and on i_reinit.
- S_IDLE: wait counter increments each cycle. When wait counter >= WAIT_CYCLES, go to S_SEND.
- S_SEND: lasts exactly 1 cycle. o_command_valid=1 and o_command_data=table[step]. Then go to S_WAIT_ACK with the timer cleared.
- S_WAIT_ACK: ack/err are sampled only in this state, never in the S_SEND cycle.
  - i_command_ack: retry_cnt clears. If step==0, go to S_WAIT_BAT. Else if step==5, go to S_DONE. Else step+1 and go to S_SEND.
  - i_command_err, or timer reaching ACK_TIMEOUT: failure event.
  - Ack and err in the same cycle: ack wins.
- S_WAIT_BAT: i_rx_valid with i_rx_data==0xAA sets step=1 and goes to S_SEND. Other received bytes are ignored, except 0xFC, which is a failure event; so is the timer reaching BAT_TIMEOUT.
- Failure event:
  - If retry_cnt==MAX_RETRY, go to S_FAIL.
  - Else retry_cnt+1 and go to S_SEND, resending the same step.
  - A BAT failure resends step 0.
  - Argument steps 2 and 4 retry the argument byte only.
- S_DONE / S_FAIL: terminal. Timers are frozen at 0. o_init_done / o_init_fail are registered state decodes.
- i_reinit, in any state and with the highest priority: next cycle goes to S_IDLE with step, retry_cnt, timers and the LED register reset. Any outstanding ack is ignored.
- Counters: all timers are 32-bit, saturating-free. They clear on every state change.

Optional Feature:
PS2_KBD_LED_UPDATE_EN
- Defined: in S_DONE, i_led_req latches i_led_val into the LED register and sets step=3, then goes to S_SEND. The normal ack/retry flow sends 0xED, then the LED byte, then returns to S_DONE (step 4 ack goes to S_DONE, not step 5). A request in any other state is dropped.
- Undefined: i_led_req and i_led_val are ignored; the port is kept and left unconnected internally.

Test Plan:
- Nominal run: WAIT_CYCLES=500. Auto-ack 3 cycles after each strobe; send 0xAA 10 cycles after the FF ack. Bytes seen: FF, F3, 20, ED, 00, F4. o_command_valid is a 1-cycle pulse each time; o_init_done=1, o_retry_cnt=0.
- Error retry: pulse i_command_err on the first F3. F3 is resent and o_retry_cnt=1; after the ack, o_retry_cnt=0 and the sequence completes.
- Timeout to fail: ACK_TIMEOUT=20, MAX_RETRY=3, no ack ever. 0xFF is sent 4 times, each send 21 cycles after the previous WAIT_ACK entry, then o_init_fail=1 with no further strobes.
- BAT fail: reply 0xFC after the FF ack. 0xFF is resent and o_retry_cnt=1; then 0xAA lets the sequence proceed.
- Reinit mid-sequence: i_reinit during S_WAIT_ACK of step 3. The next cycle is S_IDLE with tp=0. A stale ack is ignored, and after 500 cycles 0xFF is sent.
- With PS2_KBD_LED_UPDATE_EN: in S_DONE, i_led_req with i_led_val=3'b101 sends ED then 05, returns to S_DONE, and 0xF4 is not resent.

Source files
------------

// File: rtl/ps2_keyboard_init_seq.sv
// ps2_keyboard_init_seq: PS/2 keyboard power-up init (reset, BAT, typematic, LEDs, enable) with ACK/BAT timeouts and bounded retry.
// Optional runtime LED update from S_DONE when PS2_KBD_LED_UPDATE_EN is defined.
`default_nettype none

module ps2_keyboard_init_seq #(
  parameter logic [31:0] WAIT_CYCLES   = 32'd500,
  parameter logic [31:0] ACK_TIMEOUT   = 32'd100000,
  parameter logic [31:0] BAT_TIMEOUT   = 32'd50000000,
  parameter logic [3:0]  MAX_RETRY     = 4'd3,
  parameter logic [7:0]  TYPEMATIC_ARG = 8'h20,
  parameter logic [2:0]  LED_INIT      = 3'b000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_reinit,
  output logic       o_command_valid,
  output logic [7:0] o_command_data,
  input  logic       i_command_ack,
  input  logic       i_command_err,
  input  logic       i_rx_valid,
  input  logic [7:0] i_rx_data,
  input  logic       i_led_req,
  input  logic [2:0] i_led_val,
  output logic       o_init_done,
  output logic       o_init_fail,
  output logic [3:0] o_retry_cnt,
  output logic [7:0] tp
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SEND     = 3'd1,
    S_WAIT_ACK = 3'd2,
    S_WAIT_BAT = 3'd3,
    S_DONE     = 3'd4,
    S_FAIL     = 3'd5
  } state_t;

  state_t      r_state;
  logic [2:0]  r_step;
  logic [3:0]  r_retry;
  logic [31:0] r_timer;
  logic [2:0]  r_led;
  logic        r_led_mode;
  logic        r_cmd_valid;
  logic [7:0]  r_cmd_data;
  logic        r_done;
  logic        r_fail;

  state_t      w_state_nx;
  logic [2:0]  w_step_nx;
  logic [3:0]  w_retry_nx;
  logic [2:0]  w_led_nx;
  logic        w_led_mode_nx;
  logic        w_fail_ev;
  logic        w_timer_run;

  function automatic logic [7:0] cmd_byte(input logic [2:0] step, input logic [2:0] led);
    logic [7:0] b;
    case (step)
      3'd0:    b = 8'hFF;
      3'd1:    b = 8'hF3;
      3'd2:    b = TYPEMATIC_ARG;
      3'd3:    b = 8'hED;
      3'd4:    b = {5'b0, led};
      3'd5:    b = 8'hF4;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

`ifndef PS2_KBD_LED_UPDATE_EN
  logic w_unused_led;
  assign w_unused_led = ^{i_led_req, i_led_val};
`endif

  always_comb begin
    w_state_nx    = r_state;
    w_step_nx     = r_step;
    w_retry_nx    = r_retry;
    w_led_nx      = r_led;
    w_led_mode_nx = r_led_mode;
    w_fail_ev     = 1'b0;
    if (i_reinit) begin
      w_state_nx    = S_IDLE;
      w_step_nx     = 3'd0;
      w_retry_nx    = 4'd0;
      w_led_nx      = LED_INIT;
      w_led_mode_nx = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_timer >= WAIT_CYCLES) w_state_nx = S_SEND;
        end
        S_SEND: w_state_nx = S_WAIT_ACK;
        S_WAIT_ACK: begin
          // ack takes precedence over a simultaneous error
          if (i_command_ack) begin
            w_retry_nx = 4'd0;
            if (r_step == 3'd0) begin
              w_state_nx = S_WAIT_BAT;
            end else if (r_step == 3'd5 || (r_led_mode && r_step == 3'd4)) begin
              w_state_nx    = S_DONE;
              w_led_mode_nx = 1'b0;
            end else begin
              w_step_nx  = r_step + 3'd1;
              w_state_nx = S_SEND;
            end
          end else if (i_command_err || r_timer >= ACK_TIMEOUT) begin
            w_fail_ev = 1'b1;
          end
        end
        S_WAIT_BAT: begin
          if (i_rx_valid && i_rx_data == 8'hAA) begin
            w_step_nx  = 3'd1;
            w_state_nx = S_SEND;
          end else if ((i_rx_valid && i_rx_data == 8'hFC) || r_timer >= BAT_TIMEOUT) begin
            w_fail_ev = 1'b1;
          end
        end
        S_DONE: begin
`ifdef PS2_KBD_LED_UPDATE_EN
          if (i_led_req) begin
            w_led_nx      = i_led_val;
            w_step_nx     = 3'd3;
            w_led_mode_nx = 1'b1;
            w_state_nx    = S_SEND;
          end
`endif
        end
        S_FAIL:  w_state_nx = S_FAIL;
        default: w_state_nx = S_IDLE;
      endcase
      // A failure resends the current step; step stays 0 while awaiting BAT.
      if (w_fail_ev) begin
        if (r_retry == MAX_RETRY) begin
          w_state_nx = S_FAIL;
        end else begin
          w_retry_nx = r_retry + 4'd1;
          w_state_nx = S_SEND;
        end
      end
    end
  end

  assign w_timer_run = (r_state == S_IDLE) || (r_state == S_WAIT_ACK) || (r_state == S_WAIT_BAT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_step      <= 3'd0;
      r_retry     <= 4'd0;
      r_timer     <= 32'd0;
      r_led       <= LED_INIT;
      r_led_mode  <= 1'b0;
      r_cmd_valid <= 1'b0;
      r_cmd_data  <= 8'h00;
      r_done      <= 1'b0;
      r_fail      <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_step     <= w_step_nx;
      r_retry    <= w_retry_nx;
      r_led      <= w_led_nx;
      r_led_mode <= w_led_mode_nx;
      if (i_reinit || w_state_nx != r_state || !w_timer_run) begin
        r_timer <= 32'd0;
      end else begin
        r_timer <= r_timer + 32'd1;
      end
      // Outputs are registered from the next-state decode so they align with the state.
      r_cmd_valid <= (w_state_nx == S_SEND);
      r_cmd_data  <= (w_state_nx == S_SEND) ? cmd_byte(w_step_nx, w_led_nx) : 8'h00;
      r_done      <= (w_state_nx == S_DONE);
      r_fail      <= (w_state_nx == S_FAIL);
    end
  end

  assign o_command_valid = r_cmd_valid;
  assign o_command_data  = r_cmd_data;
  assign o_init_done     = r_done;
  assign o_init_fail     = r_fail;
  assign o_retry_cnt     = r_retry;
  assign tp              = {r_retry[1:0], r_step, r_state};

endmodule

`default_nettype wire
